// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator for the ULA. It compares operand A against
//   operand B DIGIT bits per cycle, starting at the most significant digit, and
//   stops at the first digit that differs. Unsigned and two's-complement modes
//   are both supported.
//
// Handshake: a request is accepted at a rising edge where start=1, en=1 and
//   ready=1. Operands and mode are captured at that edge. done pulses for exactly
//   one cycle when the result lands in s. A start seen while busy=1 is dropped and
//   is not queued.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           block enable; low aborts any operation and forces s to 0
//   start        request strobe
//   mode_signed  1 = two's-complement compare, 0 = unsigned (captured with start)
//   a, b         operands (captured with start)
//   ready        high in IDLE or DONE: a start can be accepted this cycle
//   busy         high while digits are being compared
//   done         one-cycle pulse when a new result is in s
//   s            {gt, ge, lt, le, eq, ne} for A relative to B; 0 while en=0
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation

module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             mode_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [5:0]       s,
    output logic [1:0]       state_dbg
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [5:0] REL_GT = 6'b110001;
    localparam logic [5:0] REL_LT = 6'b001101;
    localparam logic [5:0] REL_EQ = 6'b010110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [CW-1:0]     cnt;
    logic [5:0]        s_reg;

    logic [DIGIT-1:0]  a_dig;
    logic [DIGIT-1:0]  b_dig;
    logic              dig_gt;
    logic              dig_lt;
    logic              last_dig;
    logic              accept;
    logic [WIDTH-1:0]  bias;

    // Digits under comparison always sit at the top of the shift registers.
    assign a_dig    = a_sh[WIDTH-1 -: DIGIT];
    assign b_dig    = b_sh[WIDTH-1 -: DIGIT];
    assign dig_gt   = a_dig > b_dig;
    assign dig_lt   = a_dig < b_dig;
    assign last_dig = cnt == CW'(NDIG - 1);

    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned (offset-binary) order, so the digit compare is mode-agnostic.
    assign bias   = {mode_signed, {(WIDTH-1){1'b0}}};
    assign accept = start && en && ready;

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (dig_gt || dig_lt || last_dig) state_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                state_next = accept ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            s_reg <= '0;
        end else if (!en) begin
            // Abort: the result register is kept so it reappears when en returns.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sh <= a ^ bias;
                b_sh <= b ^ bias;
                cnt  <= '0;
            end else if (state == RUN) begin
                if (dig_gt) begin
                    s_reg <= REL_GT;
                end else if (dig_lt) begin
                    s_reg <= REL_LT;
                end else if (last_dig) begin
                    s_reg <= REL_EQ;
                end else begin
                    a_sh <= a_sh << DIGIT;
                    b_sh <= b_sh << DIGIT;
                    cnt  <= cnt + 1'b1;
                end
            end
        end
    end

    assign s         = en ? s_reg : 6'b0;
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;

    localparam int W    = 8;
    localparam int DG   = 2;
    localparam int NDIG = W / DG;

    logic         clk;
    logic         rst;
    logic         en;
    logic         start;
    logic         mode_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [5:0]   s;
    logic [1:0]   state_dbg;

    seq_magnitude_comparator #(.WIDTH(W), .DIGIT(DG)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .mode_signed(mode_signed),
        .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .s(s),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [5:0] exp_q[$];
    int         lat_q[$];
    logic [5:0] last_s;
    int         passed = 0;
    int         total  = 0;
    int         busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [5:0] ref_rel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic ms);
        int  va, vb;
        bit  gt, lt, eq;
        if (ms) begin
            va = int'($signed(ra));
            vb = int'($signed(rb));
        end else begin
            va = int'({24'b0, ra});
            vb = int'({24'b0, rb});
        end
        gt = va > vb;
        lt = va < vb;
        eq = va == vb;
        return {gt, gt | eq, lt, lt | eq, eq, !eq};
    endfunction

    // Busy cycles = index of first differing digit + 1; equal operands scan all.
    function automatic int ref_lat(input logic [W-1:0] ra, input logic [W-1:0] rb);
        logic [W-1:0] x;
        x = ra ^ rb;
        for (int i = 0; i < NDIG; i++) begin
            if (((x >> (W - DG * (i + 1))) & ((1 << DG) - 1)) != 0) return i + 1;
        end
        return NDIG;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [5:0] e;
                int         l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("result_s", s, e);
                check("latency", busy_cnt, l);
                check("busy_ready_excl", busy & ready, 0);
                last_s = e;
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ims, input bit expect_done);
        int guard = 0;
        @(negedge clk);
        while (!(ready && en) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("issue_wait", guard < 200, 1);
        a = ia;
        b = ib;
        mode_signed = ims;
        start = 1'b1;
        if (expect_done) begin
            exp_q.push_back(ref_rel(ia, ib, ims));
            lat_q.push_back(ref_lat(ia, ib));
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy || done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_wait", guard < 200, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; mode_signed = 1'b0; a = '0; b = '0;
        last_s = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_s", s, 0);

        // 1-3: directed compares
        issue(8'h35, 8'h94, 1'b0, 1);
        issue(8'hE1, 8'h55, 1'b0, 1);
        issue(8'hE1, 8'h55, 1'b1, 1);
        issue(8'h80, 8'h7F, 1'b1, 1);
        issue(8'h35, 8'h35, 1'b0, 1);
        issue(8'h34, 8'h35, 1'b0, 1);
        wait_drain();

        // 4: enable gating mid-operation
        issue(8'h35, 8'h35, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_off_s", s, 0);
        check("en_off_busy", busy, 0);
        check("en_off_ready", ready, 1);
        check("en_off_state", state_dbg, 0);
        a = 8'hE1; b = 8'h55; mode_signed = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        check("en_off_start_ignored", busy, 0);
        start = 1'b0;
        en = 1'b1;
        #1 check("en_restore_s", s, last_s);

        // 5: start held through RUN, accepted in the DONE cycle
        issue(8'h35, 8'h35, 1'b0, 1);
        @(negedge clk);
        a = 8'hE1; b = 8'h55; mode_signed = 1'b0; start = 1'b1;
        check("held_busy", busy, 1);
        check("held_ready", ready, 0);
        begin
            int guard = 0;
            while (!ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("held_wait", guard < 20, 1);
        end
        check("done_cycle", done, 1);
        exp_q.push_back(ref_rel(8'hE1, 8'h55, 1'b0));
        lat_q.push_back(ref_lat(8'hE1, 8'h55));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("no_idle_gap", busy, 1);
        wait_drain();

        // 6: reset in the middle of an operation
        issue(8'hFF, 8'hFF, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        last_s = '0;
        @(negedge clk);
        check("midrst_s", s, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 1);
        issue(8'h12, 8'h0F, 1'b1, 1);
        wait_drain();

        // randomized traffic, many back-to-back starts
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom_range(0, 255));
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        wait_drain();
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
